// File: rtl/parking_zone_counter.sv
// parking_zone_counter
// Multi-zone parking occupancy counter. Every raw entry/exit sensor bit is
// passed through a 2-flop synchroniser and a stability-count debouncer; the
// rising edge of the debounced level is a single counting event. Each zone
// keeps a saturating free-space count and drives green/red plus one-cycle
// reject/error pulses. The lot-wide total is a registered sum.

module parking_zone_counter #(
    parameter int unsigned ZONES           = 2,
    parameter int unsigned CAPACITY        = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    localparam int unsigned W              = $clog2(CAPACITY + 1),
    localparam int unsigned TW             = $clog2(ZONES * CAPACITY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ZONES-1:0]     entry_raw,
    input  logic [ZONES-1:0]     exit_raw,
    input  logic [ZONES-1:0]     zone_disable,
    output logic [ZONES*W-1:0]   free_spaces,
    output logic [ZONES-1:0]     green,
    output logic [ZONES-1:0]     red,
    output logic [TW-1:0]        total_free,
    output logic [ZONES-1:0]     entry_reject,
    output logic [ZONES-1:0]     exit_error
);

    // Entry bits occupy the low half of the sensor vector, exit bits the high half.
    localparam int unsigned NB = 2 * ZONES;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [W-1:0]  CAP_W     = W'(CAPACITY);
    localparam logic [TW-1:0] TOTAL_CAP = TW'(ZONES * CAPACITY);
    // The level flips on the edge where the count would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    logic [NB-1:0]    raw_bits;
    logic [NB-1:0]    sync1;
    logic [NB-1:0]    sync2;
    logic [NB-1:0]    deb;
    logic [NB-1:0]    deb_q;
    logic [CW-1:0]    stab_cnt [NB];
    logic [NB-1:0]    ev;

    logic [ZONES-1:0] entry_ev;
    logic [ZONES-1:0] exit_ev;

    logic [W-1:0]     free_q   [ZONES];
    logic [W-1:0]     free_nxt [ZONES];
    logic [ZONES-1:0] rej_nxt;
    logic [ZONES-1:0] err_nxt;
    logic [TW-1:0]    sum_free;

    assign raw_bits = {exit_raw, entry_raw};

    // Synchronise every raw bit and debounce it with a per-bit stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_bits;
            sync2 <= sync1;
            deb_q <= deb;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    stab_cnt[i] <= '0;
                end else if (stab_cnt[i] == DB_LAST) begin
                    deb[i]      <= ~deb[i];
                    stab_cnt[i] <= '0;
                end else begin
                    stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // One event per debounced rising edge; falling edges are ignored.
    always_comb begin
        ev       = deb & ~deb_q;
        entry_ev = ev[ZONES-1:0];
        exit_ev  = ev[NB-1:ZONES];
    end

    // Per-zone next count and pulse decision from the entry/exit event pair.
    always_comb begin
        rej_nxt = '0;
        err_nxt = '0;
        for (int unsigned z = 0; z < ZONES; z++) begin
            free_nxt[z] = free_q[z];
            if (entry_ev[z] && !exit_ev[z]) begin
                if ((free_q[z] != '0) && !zone_disable[z]) begin
                    free_nxt[z] = free_q[z] - 1'b1;
                end else begin
                    rej_nxt[z] = 1'b1;
                end
            end else if (exit_ev[z] && (!entry_ev[z] || zone_disable[z])) begin
                // A simultaneous entry into a closed zone is refused, so the
                // exit is applied on its own.
                if (entry_ev[z]) begin
                    rej_nxt[z] = 1'b1;
                end
                if (free_q[z] < CAP_W) begin
                    free_nxt[z] = free_q[z] + 1'b1;
                end else begin
                    err_nxt[z] = 1'b1;
                end
            end
        end
    end

    // Register zone counts and the one-cycle reject/error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned z = 0; z < ZONES; z++) begin
                free_q[z] <= CAP_W;
            end
            entry_reject <= '0;
            exit_error   <= '0;
        end else begin
            for (int unsigned z = 0; z < ZONES; z++) begin
                free_q[z] <= free_nxt[z];
            end
            entry_reject <= rej_nxt;
            exit_error   <= err_nxt;
        end
    end

    // Sum of the registered zone counts feeding the lot-wide total.
    always_comb begin
        sum_free = '0;
        for (int unsigned z = 0; z < ZONES; z++) begin
            sum_free = sum_free + TW'(free_q[z]);
        end
    end

    // Registered lot total, one cycle behind free_spaces.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_free <= TOTAL_CAP;
        end else begin
            total_free <= sum_free;
        end
    end

    // Pack counts and decode the zone lamps from registered state.
    always_comb begin
        free_spaces = '0;
        green       = '0;
        for (int unsigned z = 0; z < ZONES; z++) begin
            free_spaces[z*W +: W] = free_q[z];
            green[z]              = (free_q[z] != '0) && !zone_disable[z];
        end
        red = ~green;
    end

endmodule

// File: doc/parking_zone_counter.md
Name: parking_zone_counter

Overview:
Parametrised multi-zone parking occupancy counter for the lot controller. It serves ZONES independent zones (for example normal and handicap), each of capacity CAPACITY, and each zone has its own entry and exit sensor. Each raw sensor input is synchronised and debounced internally, and every debounced press counts as exactly one event. The block reports free spaces per zone, green/red per zone, a lot-wide total, and reject/error pulses for the gate and alarm logic.

Parameters:
ZONES, 2, number of independent zones (1..8)
CAPACITY, 5, spaces per zone; also the reset value of each counter (1..255)
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a level change (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
entry_raw  input  ZONES  raw entry sensor, bit z = zone z, asynchronous
exit_raw  input  ZONES  raw exit sensor, bit z = zone z, asynchronous
zone_disable  input  ZONES  synchronous level; 1 = zone closed to entry
free_spaces  output  ZONES*W  packed free count; zone z at [z*W +: W]; W = $clog2(CAPACITY+1)
green  output  ZONES  1 when zone has space and is enabled
red  output  ZONES  1 when zone is full or disabled
total_free  output  TW  sum of all free_spaces; TW = $clog2(ZONES*CAPACITY+1)
entry_reject  output  ZONES  one-cycle pulse: entry event refused
exit_error  output  ZONES  one-cycle pulse: exit event with zone already at CAPACITY

Behaviour:
- Input path, per raw bit:
  - 2-flop synchroniser feeds a debouncer. The debouncer holds a debounced level and a stability counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While the sync output equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - An event is the debounced level's rising edge: one cycle wide, one per press, regardless of hold time. A falling edge produces no event.
- Counter update at the clock edge after an event, per zone z, given entry event e, exit event x, free count f:
  - e=0, x=0: hold.
  - e=1, x=0: if f>0 and zone_disable[z]=0, f-1; otherwise hold and pulse entry_reject[z].
  - e=0, x=1: if f<CAPACITY, f+1; otherwise hold and pulse exit_error[z].
  - e=1, x=1: net zero, f holds, no pulses. Exception: if zone_disable[z]=1, the entry is rejected, the exit applies under the e=0/x=1 rule, and entry_reject[z] pulses.
- Count arithmetic saturates at 0 and CAPACITY and never wraps.
- Latency: raw held high, first sampled at edge 0:
  - Sync output is high after edge 1.
  - Debounced level rises at edge 1+DEBOUNCE_CYCLES.
  - free_spaces and any reject/error pulse update at edge 2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES consecutive synchronised samples produces no event.
- Output decode, combinational from registered state (no extra latency):
  - green[z] = (f>0) && !zone_disable[z].
  - red[z] = !green[z].
  - total_free is the registered sum of all zone counters and lags free_spaces by one cycle.
- zone_disable affects only entries and green/red. Exits always count. Disabling a zone does not alter its count.
- Reset: all free_spaces=CAPACITY, total_free=ZONES*CAPACITY, green=~zone_disable, red=zone_disable, entry_reject=0, exit_error=0, synchronisers/debounced levels/stability counters=0.
- Reset mid-press: a raw input still high after reset deasserts yields exactly one event, on the normal latency measured from the first post-reset edge.
- Zones are fully independent. Events in different zones on the same cycle are all applied.

Test Plan:
- ZONES=2, CAPACITY=5, DEBOUNCE_CYCLES=4: reset; hold entry_raw[0] high for 20 cycles -> free_spaces[0] 5->4 exactly 6 edges after first sample, one decrement only; zone 1 stays 5; total_free 10->9 one cycle later.
- Five clean entries on zone 1 -> free 0, green[1]=0, red[1]=1. Sixth entry -> count holds 0, entry_reject[1] pulses for exactly 1 cycle.
- Zone 0 at 5, exit press -> count holds 5, exit_error[0] pulses once. 3-cycle glitch on exit_raw[0] -> no event, no pulse.
- Zone 0 at 3, entry and exit raw rise on the same cycle -> count stays 3, no pulses. Repeat with zone_disable[0]=1 -> count 4, entry_reject[0] pulses.
- zone_disable[1]=1 at free 2 -> green[1]=0, red[1]=1 immediately. Entry rejected, count 2. Exit -> 3.
- entry_raw[0] high, reset asserted for 3 cycles and then released while input still high -> counters back to 5, then exactly one decrement to 4 at normal latency.
